sram_drain_burst_sequencer: RTL and testbench

- Sits directly downstream of the per-channel SRAM controller unit, on the write-engine side.
- Accepts a transfer descriptor (total beats) and splits it into bursts of at most a configured length.
- For each burst it waits until the controller's drain data-available count covers the burst, then pulses a drain request and issues an AW-style burst command.
- It then forwards exactly that many beats from the controller's read interface to a W-style output, asserting last on the final beat.

---
 rtl/sram_drain_burst_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_sram_drain_burst_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_drain_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sram_drain_burst_sequencer
// Purpose  : Splits a transfer descriptor (total beats) into bursts of at most
//            an effective burst limit. For each burst it waits until the SRAM
//            controller reports enough drainable beats, reserves them with a
//            one-cycle drain pulse, issues an AW-style burst command and then
//            forwards exactly that many beats from the controller read port to
//            a W-style output, flagging the final beat with w_last.
// Ports    : clk, rst_n                  - clock, synchronous active-low reset
//            desc_valid/ready/beats      - descriptor handshake and length
//            cfg_max_burst               - requested burst length (latched)
//            drain_data_avail            - beats available upstream
//            drain_req/drain_size        - one-cycle reservation pulse + size
//            sram_valid/ready/data       - beat stream from controller
//            aw_valid/ready/len          - burst command (len = beats - 1)
//            w_valid/ready/data/last     - beat stream to write engine
//            done, busy                  - completion pulse, non-idle status
// Revision : 1.0 - initial release
// ============================================================================
module sram_drain_burst_sequencer #(
  parameter int DATA_WIDTH      = 512,
  parameter int SRAM_DEPTH      = 512,
  parameter int SEG_COUNT_WIDTH = $clog2(SRAM_DEPTH) + 1,
  parameter int MAX_BURST       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       desc_valid,
  output logic                       desc_ready,
  input  logic [31:0]                desc_beats,
  input  logic [7:0]                 cfg_max_burst,
  input  logic [SEG_COUNT_WIDTH-1:0] drain_data_avail,
  output logic                       drain_req,
  output logic [7:0]                 drain_size,
  input  logic                       sram_valid,
  output logic                       sram_ready,
  input  logic [DATA_WIDTH-1:0]      sram_data,
  output logic                       aw_valid,
  input  logic                       aw_ready,
  output logic [7:0]                 aw_len,
  output logic                       w_valid,
  input  logic                       w_ready,
  output logic [DATA_WIDTH-1:0]      w_data,
  output logic                       w_last,
  output logic                       done,
  output logic                       busy
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_check = 2'd1;
  localparam logic [1:0] c_st_addr  = 2'd2;
  localparam logic [1:0] c_st_data  = 2'd3;

  localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

  logic [1:0]  state_q,      state_d;
  logic [31:0] remaining_q,  remaining_d;
  logic [7:0]  lim_q,        lim_d;
  logic [7:0]  burst_q,      burst_d;
  logic [7:0]  beat_cnt_q,   beat_cnt_d;
  logic        drain_req_q,  drain_req_d;
  logic [7:0]  drain_size_q, drain_size_d;
  logic        done_q,       done_d;

  logic [7:0]  lim_sel;
  logic [7:0]  burst_calc;
  logic [31:0] avail_ext;
  logic        avail_ok;
  logic        beat_hs;
  logic        last_beat;

  // Effective limit: zero means single-beat bursts, oversize clamps to MAX_BURST.
  always_comb begin
    lim_sel = cfg_max_burst;
    if (cfg_max_burst == 8'd0) begin
      lim_sel = 8'd1;
    end else if (cfg_max_burst > c_max_burst) begin
      lim_sel = c_max_burst;
    end
  end

  // Next burst size is min(remaining, lim); the compare against the
  // upstream count is done at full 32-bit width so large remainders are safe.
  always_comb begin
    burst_calc = lim_q;
    if (remaining_q < {24'd0, lim_q}) begin
      burst_calc = remaining_q[7:0];
    end
  end

  assign avail_ext = 32'(drain_data_avail);
  assign avail_ok  = avail_ext >= {24'd0, burst_calc};
  assign beat_hs   = (state_q == c_st_data) && sram_valid && w_ready;
  assign last_beat = (beat_cnt_q == (burst_q - 8'd1));

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    lim_d        = lim_q;
    burst_d      = burst_q;
    beat_cnt_d   = beat_cnt_q;
    drain_req_d  = 1'b0;
    drain_size_d = 8'd0;
    done_d       = 1'b0;

    case (state_q)
      c_st_idle: begin
        if (desc_valid) begin
          lim_d = lim_sel;
          if (desc_beats == 32'd0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = desc_beats;
            state_d     = c_st_check;
          end
        end
      end

      c_st_check: begin
        // Reservation is registered so drain_req lines up with the first ADDR cycle.
        if (avail_ok) begin
          burst_d      = burst_calc;
          drain_req_d  = 1'b1;
          drain_size_d = burst_calc;
          state_d      = c_st_addr;
        end
      end

      c_st_addr: begin
        if (aw_ready) begin
          beat_cnt_d = 8'd0;
          state_d    = c_st_data;
        end
      end

      c_st_data: begin
        if (beat_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (last_beat) begin
            remaining_d = remaining_q - {24'd0, burst_q};
            if (remaining_q == {24'd0, burst_q}) begin
              done_d  = 1'b1;
              state_d = c_st_idle;
            end else begin
              state_d = c_st_check;
            end
          end
        end
      end

      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= c_st_idle;
      remaining_q  <= 32'd0;
      lim_q        <= 8'd0;
      burst_q      <= 8'd0;
      beat_cnt_q   <= 8'd0;
      drain_req_q  <= 1'b0;
      drain_size_q <= 8'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      lim_q        <= lim_d;
      burst_q      <= burst_d;
      beat_cnt_q   <= beat_cnt_d;
      drain_req_q  <= drain_req_d;
      drain_size_q <= drain_size_d;
      done_q       <= done_d;
    end
  end

  assign desc_ready = (state_q == c_st_idle);
  assign busy       = (state_q != c_st_idle);
  assign drain_req  = drain_req_q;
  assign drain_size = drain_size_q;
  assign done       = done_q;

  assign aw_valid   = (state_q == c_st_addr);
  assign aw_len     = (state_q == c_st_addr) ? (burst_q - 8'd1) : 8'd0;

  // Beats pass straight through while in DATA; everything is quiet elsewhere.
  assign w_valid    = (state_q == c_st_data) && sram_valid;
  assign sram_ready = (state_q == c_st_data) && w_ready;
  assign w_data     = (state_q == c_st_data) ? sram_data : '0;
  assign w_last     = (state_q == c_st_data) && last_beat;

endmodule
`default_nettype wire

// File: tb/tb_sram_drain_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_drain_burst_sequencer
// Purpose  : Self-checking bench for sram_drain_burst_sequencer. A behavioural
//            model turns each accepted descriptor into a list of burst sizes;
//            one compare process checks drain, AW, W and done activity against
//            those lists every cycle, and directed scenarios pin the model
//            with hand-computed burst, length and last-beat positions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_drain_burst_sequencer;

  localparam int DW    = 512;
  localparam int DEPTH = 512;
  localparam int SCW   = $clog2(DEPTH) + 1;
  localparam int MAXB  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           desc_valid;
  logic           desc_ready;
  logic [31:0]    desc_beats;
  logic [7:0]     cfg_max_burst;
  logic [SCW-1:0] drain_data_avail;
  logic           drain_req;
  logic [7:0]     drain_size;
  logic           sram_valid;
  logic           sram_ready;
  logic [DW-1:0]  sram_data;
  logic           aw_valid;
  logic           aw_ready;
  logic [7:0]     aw_len;
  logic           w_valid;
  logic           w_ready;
  logic [DW-1:0]  w_data;
  logic           w_last;
  logic           done;
  logic           busy;

  sram_drain_burst_sequencer #(
    .DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH), .SEG_COUNT_WIDTH(SCW), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_beats(desc_beats),
    .cfg_max_burst(cfg_max_burst), .drain_data_avail(drain_data_avail),
    .drain_req(drain_req), .drain_size(drain_size),
    .sram_valid(sram_valid), .sram_ready(sram_ready), .sram_data(sram_data),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input bit ok, input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int k);
    logic [31:0] v;
    v = 32'(k) * 32'h9E3779B1 + 32'h0000_1234;
    return {(DW/32){v}};
  endfunction

  // Stimulus knobs
  int  w_ready_pct = 100;
  int  sram_gap_pct = 0;
  int  aw_delay = 0;
  bit  aw_hold_chk = 0;
  bit  avail_rand = 0;

  // Upstream source / downstream sink / AW responder
  int src_idx = 0;
  int aw_cnt = 0;
  initial begin
    bit hs;
    sram_valid = 1'b0;
    w_ready = 1'b0;
    aw_ready = 1'b0;
    sram_data = beat_data(0);
    forever begin
      @(negedge clk);
      hs = sram_valid && sram_ready;
      @(posedge clk);
      #1;
      if (hs) src_idx++;
      if (!(sram_valid && !hs))
        sram_valid = ($urandom_range(0, 99) >= sram_gap_pct);
      sram_data = beat_data(src_idx);
      w_ready = ($urandom_range(0, 99) < w_ready_pct);
      if (!aw_valid) aw_cnt = 0;
      aw_ready = aw_valid && (aw_cnt >= aw_delay);
      if (aw_valid) aw_cnt++;
      if (avail_rand) drain_data_avail = SCW'($urandom_range(0, 40));
    end
  end

  // Behavioural model state: one entry per expected burst, per interface
  int drain_q[$];
  int aw_q[$];
  int w_q[$];
  int exp_done = 0;
  int w_in_burst = 0;
  int w_seen = 0;
  int desc_base = 0;
  int done_cnt = 0;
  int aw_hold = 0;
  int first_drain_cyc = -1;
  bit prev_drain = 0;
  int avail_prev = 0;
  int drain_log[$];
  int awlen_log[$];
  int last_log[$];

  always @(negedge clk) begin
    bit hs_w;
    bit exp_last;
    hs_w = w_valid && w_ready;
    if (!rst_n) begin
      drain_q.delete(); aw_q.delete(); w_q.delete();
      exp_done = 0; w_in_burst = 0; aw_hold = 0; prev_drain = 0;
      if (hs_w) w_seen++;
    end else begin
      if (drain_req) begin
        chk(!prev_drain, "drain_req_single_cycle", prev_drain, 0);
        chk(drain_q.size() != 0, "drain_req_expected", drain_q.size(), 1);
        if (drain_q.size() != 0) begin
          chk(drain_size == drain_q[0], "drain_size", drain_size, drain_q[0]);
          chk(avail_prev >= int'(drain_size), "drain_avail_covers", avail_prev, drain_size);
          chk(drain_q.size() == aw_q.size(), "drain_before_aw", drain_q.size(), aw_q.size());
          drain_log.push_back(int'(drain_size));
          if (first_drain_cyc < 0) first_drain_cyc = cyc;
          void'(drain_q.pop_front());
        end
      end
      if (aw_valid) begin
        chk(aw_q.size() != 0, "aw_expected", aw_q.size(), 1);
        if (aw_q.size() != 0) begin
          chk(aw_len == 8'(aw_q[0] - 1), "aw_len", aw_len, aw_q[0] - 1);
          if (aw_ready) begin
            chk(drain_q.size() == aw_q.size() - 1, "aw_after_drain", drain_q.size(), aw_q.size() - 1);
            if (aw_hold_chk) chk(aw_hold == aw_delay, "aw_hold_cycles", aw_hold, aw_delay);
            awlen_log.push_back(int'(aw_len));
            void'(aw_q.pop_front());
            aw_hold = 0;
          end else begin
            aw_hold++;
          end
        end
      end
      if (!w_ready) chk(!sram_ready, "sram_ready_follows_w_ready", sram_ready, 0);
      if (hs_w) begin
        chk(w_q.size() != 0, "w_beat_expected", w_q.size(), 1);
        if (w_q.size() != 0) begin
          chk(aw_q.size() == w_q.size() - 1, "w_after_aw", aw_q.size(), w_q.size() - 1);
          chk(w_data == beat_data(w_seen), "w_data", w_data, beat_data(w_seen));
          exp_last = (w_in_burst == w_q[0] - 1);
          chk(w_last == exp_last, "w_last", w_last, exp_last);
          if (exp_last) begin
            last_log.push_back(w_seen + 1 - desc_base);
            void'(w_q.pop_front());
            w_in_burst = 0;
          end else begin
            w_in_burst++;
          end
        end
        w_seen++;
      end
      if (done) begin
        chk(exp_done > 0 && w_q.size() == 0 && aw_q.size() == 0 && drain_q.size() == 0,
            "done_when_complete", {exp_done, w_q.size()}, {32'd1, 32'd0});
        if (exp_done > 0) exp_done--;
        done_cnt++;
      end
      prev_drain = drain_req;
    end
    avail_prev = int'(drain_data_avail);
  end

  task automatic clear_logs();
    drain_log.delete(); awlen_log.delete(); last_log.delete();
    first_drain_cyc = -1;
  endtask

  task automatic chk_log(input string nm, input int got[$], input int e[$]);
    chk(got.size() == e.size(), {nm, "_count"}, got.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < got.size()) chk(got[i] == e[i], nm, got[i], e[i]);
  endtask

  // Accepts a descriptor and appends its burst plan to the model.
  task automatic run_desc(input int beats, input int cfg);
    int lim;
    int rem;
    int b;
    bit got;
    got = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (desc_ready) begin got = 1; break; end
    end
    chk(got, "desc_ready_timeout", got, 1);
    lim = (cfg == 0) ? 1 : ((cfg > MAXB) ? MAXB : cfg);
    rem = beats;
    while (rem > 0) begin
      b = (rem < lim) ? rem : lim;
      drain_q.push_back(b); aw_q.push_back(b); w_q.push_back(b);
      rem -= b;
    end
    exp_done++;
    desc_base = w_seen;
    desc_valid = 1'b1;
    desc_beats = 32'(beats);
    cfg_max_burst = 8'(cfg);
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int waited);
    bit got;
    got = 0;
    waited = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      waited++;
      if (done) begin got = 1; break; end
    end
    chk(got, "done_timeout", got, 1);
  endtask

  task automatic set_knobs(input int wr, input int gap, input int awd);
    w_ready_pct = wr; sram_gap_pct = gap; aw_delay = awd;
  endtask

  int e[$];
  int waited;
  int d0;
  int raise_cyc;
  int base;

  initial begin
    rst_n = 1'b0;
    desc_valid = 1'b0;
    desc_beats = 32'd0;
    cfg_max_burst = 8'd0;
    drain_data_avail = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({drain_req, aw_valid, done, busy, w_last, w_valid, sram_ready} == 7'd0,
        "reset_outputs", {drain_req, aw_valid, done, busy, w_last, w_valid, sram_ready}, 0);
    chk({drain_size, aw_len} == 16'd0, "reset_size_len", {drain_size, aw_len}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk(desc_ready == 1'b1, "desc_ready_after_reset", desc_ready, 1);
    chk(busy == 1'b0, "idle_after_reset", busy, 0);

    // Three bursts with ample data available
    drain_data_avail = SCW'(64);
    clear_logs(); d0 = done_cnt;
    run_desc(40, 16); wait_done(2000, waited);
    e = {16, 16, 8};  chk_log("t1_drain_size", drain_log, e);
    e = {15, 15, 7};  chk_log("t1_aw_len", awlen_log, e);
    e = {16, 32, 40}; chk_log("t1_last_pos", last_log, e);
    repeat (3) @(negedge clk);
    chk(done_cnt - d0 == 1, "t1_done_count", done_cnt - d0, 1);

    // Stall in CHECK until data-available covers the burst
    drain_data_avail = SCW'(5);
    clear_logs();
    run_desc(16, 16);
    repeat (20) @(posedge clk);
    #1 drain_data_avail = SCW'(16);
    raise_cyc = cyc;
    wait_done(2000, waited);
    chk(first_drain_cyc == raise_cyc + 1, "t2_drain_after_avail", first_drain_cyc, raise_cyc + 1);
    e = {16}; chk_log("t2_drain_size", drain_log, e);
    e = {16}; chk_log("t2_last_pos", last_log, e);

    // Slow AW accept, half-rate sink, gapped source
    drain_data_avail = SCW'(64);
    clear_logs(); set_knobs(50, 30, 3); aw_hold_chk = 1;
    run_desc(40, 16); wait_done(4000, waited);
    e = {15, 15, 7}; chk_log("t3_aw_len", awlen_log, e);
    aw_hold_chk = 0; set_knobs(100, 0, 0);

    // Zero-length descriptor
    clear_logs(); base = w_seen;
    run_desc(0, 16); wait_done(10, waited);
    chk(waited == 1, "t4_done_next_cycle", waited, 1);
    repeat (3) @(negedge clk);
    chk(drain_log.size() == 0 && awlen_log.size() == 0 && w_seen == base,
        "t4_no_activity", {drain_log.size(), awlen_log.size()}, 0);

    // Burst-limit edges
    clear_logs();
    run_desc(3, 0); wait_done(1000, waited);
    e = {1, 1, 1}; chk_log("t5_drain_size", drain_log, e);
    e = {0, 0, 0}; chk_log("t5_aw_len", awlen_log, e);
    e = {1, 2, 3}; chk_log("t5_last_pos", last_log, e);
    clear_logs();
    run_desc(32, 200); wait_done(1000, waited);
    e = {16, 16}; chk_log("t5_clamp_drain", drain_log, e);

    // Reset in the middle of a burst
    clear_logs(); base = w_seen;
    run_desc(16, 16);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (w_seen - base >= 5) break;
    end
    chk(w_seen - base >= 5, "t6_reach_beat5", w_seen - base, 5);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({drain_req, aw_valid, done, busy, w_last, w_valid, sram_ready} == 7'd0,
        "t6_outputs_after_reset", {drain_req, aw_valid, done, busy, w_last, w_valid, sram_ready}, 0);
    chk({drain_size, aw_len} == 16'd0 && w_data == '0, "t6_size_len_data", {drain_size, aw_len}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk(desc_ready == 1'b1, "t6_desc_ready", desc_ready, 1);
    clear_logs();
    run_desc(4, 16); wait_done(1000, waited);
    e = {4}; chk_log("t6_last_pos", last_log, e);

    // Randomized descriptors under random back-pressure and availability
    avail_rand = 1;
    set_knobs(70, 20, 0);
    for (int n = 0; n < 10; n++) begin
      aw_delay = $urandom_range(0, 2);
      run_desc($urandom_range(0, 50), $urandom_range(0, 255));
      wait_done(4000, waited);
    end
    avail_rand = 0;

    repeat (5) @(negedge clk);
    chk(drain_q.size() == 0 && aw_q.size() == 0 && w_q.size() == 0 && exp_done == 0,
        "model_drained", {drain_q.size(), aw_q.size(), w_q.size()}, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
